// File: rtl/intr_seq_if.sv
// Handshake bundle between intr_seq and the surrounding control unit, CCR and stack.
// The master drives requests and pipeline status; the slave is the sequencer.
interface intr_seq_if;
    logic       INTR;
    logic       RTI;
    logic       PIPE_EMPTY;
    logic [7:0] PC_CUR;
    logic       F_SAVE;
    logic       F_RESTORE;
    logic       PUSH_PC;
    logic       POP_PC;
    logic [7:0] PC_OUT;
    logic       LOAD_VEC;
    logic [7:0] VEC_OUT;
    logic       STALL;
    logic       FLUSH;
    logic       INTR_ACK;
    logic       IN_ISR;

    modport master (
        output INTR, RTI, PIPE_EMPTY, PC_CUR,
        input  F_SAVE, F_RESTORE, PUSH_PC, POP_PC, PC_OUT, LOAD_VEC, VEC_OUT,
               STALL, FLUSH, INTR_ACK, IN_ISR
    );

    modport slave (
        input  INTR, RTI, PIPE_EMPTY, PC_CUR,
        output F_SAVE, F_RESTORE, PUSH_PC, POP_PC, PC_OUT, LOAD_VEC, VEC_OUT,
               STALL, FLUSH, INTR_ACK, IN_ISR
    );
endinterface

// File: rtl/intr_seq.sv
// Interrupt entry/return sequencer: CCR save/restore, PC push/pop, stall/flush, vector load.
// Define INTR_SYNC_EN to pass INTR through a two-flop synchronizer first.
module intr_seq #(
    parameter logic [7:0] VEC_ADDR = 8'h01
) (
    input  logic       CLK,
    input  logic       RST,
    intr_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_SAVE, S_VECTOR, S_ISR, S_RESTORE, S_RESUME
    } state_t;

    state_t     state, nxt;
    logic       pending;
    logic       in_isr;
    logic       intr_s;
    logic [7:0] pc_cap;
    logic       f_save, f_restore, push_pc, pop_pc, load_vec, stall, flush, intr_ack;

`ifdef INTR_SYNC_EN
    logic [1:0] intr_sync;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) intr_sync <= '0;
        else      intr_sync <= {intr_sync[0], bus.INTR};
    end

    assign intr_s = intr_sync[1];
`else
    assign intr_s = bus.INTR;
`endif

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (pending)        nxt = S_DRAIN;
            S_DRAIN:   if (bus.PIPE_EMPTY) nxt = S_SAVE;
            S_SAVE:                        nxt = S_VECTOR;
            S_VECTOR:                      nxt = S_ISR;
            S_ISR:     if (bus.RTI)        nxt = S_RESTORE;
            S_RESTORE:                     nxt = S_RESUME;
            S_RESUME:                      nxt = S_IDLE;
            default:                       nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each one is aligned with its state cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            pending   <= 1'b0;
            in_isr    <= 1'b0;
            pc_cap    <= '0;
            f_save    <= 1'b0;
            f_restore <= 1'b0;
            push_pc   <= 1'b0;
            pop_pc    <= 1'b0;
            load_vec  <= 1'b0;
            stall     <= 1'b0;
            flush     <= 1'b0;
            intr_ack  <= 1'b0;
        end else begin
            state <= nxt;

            if (state == S_SAVE) pending <= 1'b0;
            else if (intr_s)     pending <= 1'b1;

            if (state == S_DRAIN && bus.PIPE_EMPTY) pc_cap <= bus.PC_CUR;

            if (state == S_VECTOR)       in_isr <= 1'b1;
            else if (state == S_RESTORE) in_isr <= 1'b0;

            f_save    <= (nxt == S_SAVE);
            push_pc   <= (nxt == S_SAVE);
            intr_ack  <= (nxt == S_SAVE);
            f_restore <= (nxt == S_RESTORE);
            pop_pc    <= (nxt == S_RESTORE);
            load_vec  <= (nxt == S_VECTOR);
            flush     <= (nxt == S_VECTOR) || (nxt == S_RESUME);
            stall     <= (nxt == S_DRAIN) || (nxt == S_SAVE) || (nxt == S_VECTOR) ||
                         (nxt == S_RESTORE) || (nxt == S_RESUME);
        end
    end

    assign bus.F_SAVE    = f_save;
    assign bus.F_RESTORE = f_restore;
    assign bus.PUSH_PC   = push_pc;
    assign bus.POP_PC    = pop_pc;
    assign bus.PC_OUT    = pc_cap;
    assign bus.LOAD_VEC  = load_vec;
    assign bus.VEC_OUT   = VEC_ADDR;
    assign bus.STALL     = stall;
    assign bus.FLUSH     = flush;
    assign bus.INTR_ACK  = intr_ack;
    assign bus.IN_ISR    = in_isr;
endmodule

// File: tb/tb_intr_seq.sv
// Scoreboard bench for intr_seq: stimulus predicts timed output events, a negedge monitor checks them.
// Honours INTR_SYNC_EN the same way the design does (two extra cycles of entry latency).
module tb_intr_seq;
    logic CLK;
    logic RST;

    intr_seq_if bus();

    intr_seq #(.VEC_ADDR(8'h01)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // {F_SAVE,F_RESTORE,PUSH_PC,POP_PC,LOAD_VEC,STALL,FLUSH,INTR_ACK,IN_ISR}
    localparam logic [8:0] W_DRAIN   = 9'b0_0_0_0_0_1_0_0_0;
    localparam logic [8:0] W_SAVE    = 9'b1_0_1_0_0_1_0_1_0;
    localparam logic [8:0] W_VECTOR  = 9'b0_0_0_0_1_1_1_0_0;
    localparam logic [8:0] W_ISR     = 9'b0_0_0_0_0_0_0_0_1;
    localparam logic [8:0] W_RESTORE = 9'b0_1_0_1_0_1_0_0_1;
    localparam logic [8:0] W_RESUME  = 9'b0_0_0_0_0_1_1_0_0;

    typedef struct {
        int unsigned stamp;
        logic [8:0]  word;
        logic        chk_pc;
        logic [7:0]  pc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          n_vec = 0;
    int          n_bad = 0;
    logic [8:0]  dut_word;
    exp_t        head;

    assign dut_word = {bus.F_SAVE, bus.F_RESTORE, bus.PUSH_PC, bus.POP_PC, bus.LOAD_VEC,
                       bus.STALL, bus.FLUSH, bus.INTR_ACK, bus.IN_ISR};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: any visible output activity must match the oldest predicted event.
    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].stamp < cyc) begin
            n_vec++;
            n_bad++;
            $display("FAIL missing_event: cycle %0d saw nothing, required word %b at cycle %0d",
                     cyc, sb[0].word, sb[0].stamp);
            void'(sb.pop_front());
        end
        if (dut_word != '0) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_event: cycle %0d word %b, required no activity", cyc, dut_word);
            end else begin
                head = sb.pop_front();
                if (head.stamp != cyc || dut_word != head.word ||
                    (head.chk_pc && bus.PC_OUT != head.pc) || bus.VEC_OUT != 8'h01) begin
                    n_bad++;
                    $display("FAIL event: cycle %0d word %b pc %h vec %h, required cycle %0d word %b pc %h vec 01",
                             cyc, dut_word, bus.PC_OUT, bus.VEC_OUT, head.stamp, head.word,
                             head.chk_pc ? head.pc : bus.PC_OUT);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic push(input int unsigned stamp, input logic [8:0] word,
                        input logic chk_pc, input logic [7:0] pc);
        sb.push_back('{stamp: stamp, word: word, chk_pc: chk_pc, pc: pc});
    endtask

    // Called one cycle before DRAIN becomes visible; returns in the VECTOR cycle.
    task automatic entry_phase(input int unsigned d, input logic [7:0] pc);
        int unsigned base;
        base = cyc + 1;
        for (int unsigned i = 0; i <= d; i++) push(base + i, W_DRAIN, 1'b0, 8'h00);
        push(base + d + 1, W_SAVE, 1'b1, pc);
        push(base + d + 2, W_VECTOR, 1'b0, 8'h00);
        bus.PIPE_EMPTY = 1'b0;
        repeat (d + 1) begin
            bus.PC_CUR = 8'($urandom);
            tick();
        end
        bus.PIPE_EMPTY = 1'b1;
        bus.PC_CUR     = pc;
        tick();
        bus.PIPE_EMPTY = 1'($urandom);
        bus.PC_CUR     = 8'($urandom);
        tick();
    endtask

    // Called from IDLE: one-cycle INTR pulse, then the full entry.
    task automatic start_entry(input int unsigned d, input logic [7:0] pc);
        bus.INTR       = 1'b1;
        bus.RTI        = 1'b0;
        bus.PIPE_EMPTY = 1'b0;
        bus.PC_CUR     = 8'($urandom);
        tick();
        bus.INTR = 1'b0;
`ifdef INTR_SYNC_EN
        repeat (2) tick();
`endif
        entry_phase(d, pc);
    endtask

    // Called in the first ISR cycle; returns in the first IDLE cycle after RESUME.
    task automatic isr_phase(input int unsigned w, input logic intr_too);
        int unsigned c;
        c = cyc;
        for (int unsigned i = 0; i <= w; i++) push(c + i, W_ISR, 1'b0, 8'h00);
        push(c + w + 1, W_RESTORE, 1'b0, 8'h00);
        push(c + w + 2, W_RESUME, 1'b0, 8'h00);
        bus.INTR = 1'b0;
        bus.RTI  = 1'b0;
        repeat (w) begin
            bus.PIPE_EMPTY = 1'($urandom);
            tick();
        end
        bus.RTI  = 1'b1;
        bus.INTR = intr_too;
        tick();
        bus.RTI  = 1'b0;
        bus.INTR = 1'b0;
        tick();
        tick();
    endtask

    task automatic idle(input int unsigned n);
        bus.INTR = 1'b0;
        repeat (n) begin
            bus.RTI        = 1'($urandom);
            bus.PIPE_EMPTY = 1'($urandom);
            bus.PC_CUR     = 8'($urandom);
            tick();
        end
        bus.RTI        = 1'b0;
        bus.PIPE_EMPTY = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic again;
        bus.INTR       = 1'b0;
        bus.RTI        = 1'b0;
        bus.PIPE_EMPTY = 1'b0;
        bus.PC_CUR     = 8'h00;
        RST            = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_strobes", 32'(dut_word), 32'h0);
        check("reset_pc_out", 32'(bus.PC_OUT), 32'h0);
        check("reset_vec_out", 32'(bus.VEC_OUT), 32'h01);
        RST = 1'b1;
        tick();

        // RTI outside ISR must be ignored
        bus.RTI = 1'b1;
        tick();
        bus.RTI = 1'b0;
        idle(3);

        // basic entry then return
        start_entry(0, 8'h3A);
        tick();
        isr_phase(2, 1'b0);
        idle(2);

        // pipeline not empty for three cycles
        start_entry(3, 8'($urandom));
        tick();
        isr_phase(0, 1'b0);
        idle(2);

        // RTI and INTR together in ISR: return, one IDLE cycle, second entry
        start_entry(1, 8'($urandom));
        tick();
        isr_phase(1, 1'b1);
        entry_phase($urandom_range(0, 2), 8'($urandom));
        tick();
        isr_phase(0, 1'b0);
        idle(3);

        // reset dropped during VECTOR
        start_entry(1, 8'($urandom));
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("midreset_strobes", 32'(dut_word), 32'h0);
        check("midreset_pc_out", 32'(bus.PC_OUT), 32'h0);
        check("midreset_vec_out", 32'(bus.VEC_OUT), 32'h01);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(8);

        for (int i = 0; i < 25; i++) begin
            again = 1'($urandom);
            start_entry($urandom_range(0, 4), 8'($urandom));
            tick();
            isr_phase($urandom_range(0, 4), again);
            if (again) begin
                entry_phase($urandom_range(0, 3), 8'($urandom));
                tick();
                isr_phase($urandom_range(0, 3), 1'b0);
            end
            idle($urandom_range(1, 4));
        end

        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        if (sb.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d events outstanding, required 0", sb.size());
        end
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
